// File: rtl/mips_control_ifid_immediate_sequencer.sv
// IF/ID stage: decodes opcode into immediate extend/shift control and forms the 32-bit immediate.
// Latency: one cycle from accept to outputs when the buffer is empty or popping that cycle.
// Backpressure: a 2-entry skid buffer; inReady is registered ("not full"), and flush empties both entries.
module mips_control_ifid_immediate_sequencer #(
  parameter bit BRANCH_SHIFT          = 1'b1,
  parameter bit DECODE_DEFAULT_SIGNED = 1'b1
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        inValid,
  output logic        inReady,
  input  logic [31:0] inInstr,
  input  logic        flush,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] outInstr,
  output logic [2:0]  outControl,
  output logic [31:0] outImm,
  output logic        outHasImm
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // One buffered word together with its decode, so the head never needs re-decoding.
  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  ctrl;
    logic [31:0] imm;
    logic        has_imm;
  } entry_t;

  localparam entry_t ENTRY_RST = '{instr: 32'h0, ctrl: 3'b100, imm: 32'h0, has_imm: 1'b0};

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;

  logic        accept;
  logic        pop;
  logic [5:0]  opcode;
  logic        ext_signed;
  logic [1:0]  shift_sel;
  logic        has_imm;
  logic [31:0] imm_ext;
  logic [31:0] imm_shifted;
  entry_t      in_entry;

  // Ready/valid are pure functions of the registered occupancy.
  assign inReady  = (state_q != ST_TWO);
  assign outValid = (state_q != ST_EMPTY);
  assign accept   = inValid & inReady;
  assign pop      = outValid & outReady;

  assign outInstr   = head_q.instr;
  assign outControl = head_q.ctrl;
  assign outImm     = head_q.imm;
  assign outHasImm  = head_q.has_imm;

  assign opcode = inInstr[31:26];

  // Opcode -> {extend, shift, has_imm} for the incoming word.
  always_comb begin
    ext_signed = DECODE_DEFAULT_SIGNED;
    shift_sel  = 2'd0;
    has_imm    = 1'b0;
    case (opcode)
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        ext_signed = 1'b1;
        has_imm    = 1'b1;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        ext_signed = 1'b0;
        has_imm    = 1'b1;
      end
      6'h0F: begin
        ext_signed = 1'b0;
        shift_sel  = 2'd2;
        has_imm    = 1'b1;
      end
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
        ext_signed = 1'b1;
        shift_sel  = BRANCH_SHIFT ? 2'd1 : 2'd0;
        has_imm    = 1'b1;
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
      6'h28, 6'h29, 6'h2A, 6'h2B: begin
        ext_signed = 1'b1;
        has_imm    = 1'b1;
      end
      default: begin
        ext_signed = DECODE_DEFAULT_SIGNED;
      end
    endcase
  end

  // Extend then shift; the reserved shift code passes the extended value through.
  always_comb begin
    imm_ext = ext_signed ? {{16{inInstr[15]}}, inInstr[15:0]} : {16'h0, inInstr[15:0]};
    case (shift_sel)
      2'd1:    imm_shifted = imm_ext << 2;
      2'd2:    imm_shifted = imm_ext << 16;
      default: imm_shifted = imm_ext;
    endcase
    in_entry = '{instr: inInstr, ctrl: {ext_signed, shift_sel}, imm: imm_shifted, has_imm: has_imm};
  end

  // Occupancy FSM and entry movement; flush wins over any same-cycle accept or pop.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_d = in_entry;
          end else if (accept) begin
            tail_d  = in_entry;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and entry registers; reset restores the documented idle output values.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_EMPTY;
      head_q  <= ENTRY_RST;
      tail_q  <= ENTRY_RST;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_mips_control_ifid_immediate_sequencer.sv
// Bench for the IF/ID immediate sequencer: two instances (branch shift on/off) share one stimulus.
// Latency: compares outputs 1 time unit after each rising edge against a queue-based model.
// Backpressure: the source holds a word until the model says the buffer has room.
module tb_mips_control_ifid_immediate_sequencer;

  logic        clock;
  logic        resetN;
  logic        inValid;
  logic        inReady, inReady2;
  logic [31:0] inInstr;
  logic        flush;
  logic        outValid, outValid2;
  logic        outReady;
  logic [31:0] outInstr, outInstr2;
  logic [2:0]  outControl, outControl2;
  logic [31:0] outImm, outImm2;
  logic        outHasImm, outHasImm2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mq[$];

  mips_control_ifid_immediate_sequencer #(.BRANCH_SHIFT(1'b1), .DECODE_DEFAULT_SIGNED(1'b1)) dut (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady), .inInstr(inInstr),
    .flush(flush), .outValid(outValid), .outReady(outReady), .outInstr(outInstr),
    .outControl(outControl), .outImm(outImm), .outHasImm(outHasImm)
  );

  mips_control_ifid_immediate_sequencer #(.BRANCH_SHIFT(1'b0), .DECODE_DEFAULT_SIGNED(1'b1)) dut_nb (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady2), .inInstr(inInstr),
    .flush(flush), .outValid(outValid2), .outReady(outReady), .outInstr(outInstr2),
    .outControl(outControl2), .outImm(outImm2), .outHasImm(outHasImm2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference decode straight from the opcode table.
  function automatic logic [2:0] ref_ctrl(input logic [31:0] w, input bit bshift);
    logic [5:0] op;
    op = w[31:26];
    if (op inside {[6'h08:6'h0B], [6'h20:6'h26], [6'h28:6'h2B]}) return 3'b100;
    if (op inside {[6'h0C:6'h0E]}) return 3'b000;
    if (op == 6'h0F) return 3'b010;
    if (op inside {6'h01, [6'h04:6'h07]}) return bshift ? 3'b101 : 3'b100;
    return 3'b100;
  endfunction

  function automatic logic ref_has(input logic [31:0] w);
    return w[31:26] inside {6'h01, [6'h04:6'h0F], [6'h20:6'h26], [6'h28:6'h2B]};
  endfunction

  // Immediate as an integer: signed/unsigned value times the shift factor, modulo 2^32.
  function automatic logic [31:0] ref_imm(input logic [31:0] w, input bit bshift);
    logic [2:0] c;
    longint     v;
    c = ref_ctrl(w, bshift);
    v = longint'(w[15:0]);
    if (c[2] && w[15]) v = v - 65536;
    if (c[1:0] == 2'd1) v = v * 4;
    else if (c[1:0] == 2'd2) v = v * 65536;
    return v[31:0];
  endfunction

  // Apply inputs for one cycle, advance the model at the edge, then settle past the edge.
  task automatic drive_cycle(input logic v, input logic [31:0] w, input logic r, input logic f);
    bit acc, pp;
    inValid  = v;
    inInstr  = w;
    outReady = r;
    flush    = f;
    acc = v && (mq.size() < 2);
    pp  = r && (mq.size() > 0);
    @(posedge clock);
    if (f) begin
      mq.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(w);
    end
    #1;
  endtask

  task automatic test_reset();
    resetN   = 1'b0;
    inValid  = 1'b1;
    inInstr  = 32'h2008FFFC;
    outReady = 1'b1;
    flush    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL reset_outValid got %b want 0", outValid); end
    n_tests++; if (inReady !== 1'b1) begin n_fail++; $display("FAIL reset_inReady got %b want 1", inReady); end
    n_tests++; if (outControl !== 3'b100) begin n_fail++; $display("FAIL reset_ctrl got %b want 100", outControl); end
    n_tests++; if (outInstr !== 32'h0 || outImm !== 32'h0 || outHasImm !== 1'b0) begin
      n_fail++; $display("FAIL reset_data instr=%h imm=%h has=%b want 0/0/0", outInstr, outImm, outHasImm);
    end
    resetN = 1'b1;
    mq.delete();
    drive_cycle(1'b1, 32'h2008FFFC, 1'b1, 1'b0);
    n_tests++; if (outValid !== 1'b1 || outInstr !== 32'h2008FFFC) begin
      n_fail++; $display("FAIL reset_first_accept valid=%b instr=%h want 1/2008fffc", outValid, outInstr);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_stream();
    logic [31:0] words[4];
    logic [31:0] e_imm[4];
    logic [2:0]  e_ctl[4];
    words = '{32'h2008FFFC, 32'h3508FFFC, 32'h3C081234, 32'h1109FFFF};
    e_imm = '{32'hFFFFFFFC, 32'h0000FFFC, 32'h12340000, 32'hFFFFFFFC};
    e_ctl = '{3'b100, 3'b000, 3'b010, 3'b101};
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, words[k], 1'b1, 1'b0);
      n_tests++;
      if (outValid !== 1'b1 || outInstr !== words[k] || outImm !== e_imm[k] || outControl !== e_ctl[k] || outHasImm !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d v=%b instr=%h imm=%h ctl=%b has=%b want 1/%h/%h/%b/1",
                 k, outValid, outInstr, outImm, outControl, outHasImm, words[k], e_imm[k], e_ctl[k]);
      end
    end
    n_tests++;
    if (outImm2 !== 32'hFFFFFFFF || outControl2 !== 3'b100) begin
      n_fail++; $display("FAIL stream_beq_noshift imm=%h ctl=%b want ffffffff/100", outImm2, outControl2);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b want 0", outValid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] src[3];
    logic [31:0] got[$];
    int idx;
    src = '{32'h8C410004, 32'h24020007, 32'hAC43FFF0};
    idx = 0;
    for (int c = 0; c < 4 && idx < 3; c++) begin
      if (mq.size() < 2) begin
        drive_cycle(1'b1, src[idx], 1'b0, 1'b0);
        idx++;
      end else begin
        drive_cycle(1'b1, src[idx], 1'b0, 1'b0);
      end
    end
    n_tests++; if (idx !== 2) begin n_fail++; $display("FAIL bp_accepts got %0d want 2", idx); end
    n_tests++; if (inReady !== 1'b0) begin n_fail++; $display("FAIL bp_inReady got %b want 0", inReady); end
    n_tests++; if (outInstr !== src[0]) begin n_fail++; $display("FAIL bp_head_stable got %h want %h", outInstr, src[0]); end
    for (int c = 0; c < 10; c++) begin
      if (outValid === 1'b1) got.push_back(outInstr);
      if (idx < 3) begin
        if (mq.size() < 2 || mq.size() == 2 && 1'b1) begin
          if (mq.size() < 2 || mq.size() > 0) begin
            if (mq.size() < 2) begin
              drive_cycle(1'b1, src[idx], 1'b1, 1'b0);
              idx++;
            end else begin
              drive_cycle(1'b1, src[idx], 1'b1, 1'b0);
            end
          end
        end
      end else begin
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      end
    end
    n_tests++;
    if (got.size() !== 3) begin
      n_fail++; $display("FAIL bp_count got %0d want 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (got[k] !== src[k]) begin n_fail++; $display("FAIL bp_order_%0d got %h want %h", k, got[k], src[k]); end
      end
    end
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 32'h2001AAAA, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h2002BBBB, 1'b0, 1'b0);
    n_tests++; if (inReady !== 1'b0) begin n_fail++; $display("FAIL flush_full got %b want 0", inReady); end
    drive_cycle(1'b1, 32'h2003CCCC, 1'b1, 1'b1);
    n_tests++; if (outValid !== 1'b0 || inReady !== 1'b1) begin
      n_fail++; $display("FAIL flush_state valid=%b ready=%b want 0/1", outValid, inReady);
    end
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL flush_leak_%0d got %b want 0", c, outValid); end
    end
  endtask

  task automatic test_no_imm();
    logic [31:0] w[2];
    w = '{32'h01095020, 32'h08000010};
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b1, w[k], 1'b1, 1'b0);
      n_tests++;
      if (outHasImm !== 1'b0 || outControl !== 3'b100 || outImm !== ref_imm(w[k], 1'b1)) begin
        n_fail++; $display("FAIL no_imm_%0d has=%b ctl=%b imm=%h want 0/100/%h", k, outHasImm, outControl, outImm, ref_imm(w[k], 1'b1));
      end
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0]  ops[18];
    logic [31:0] w;
    int bad;
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h0B, 6'h0C, 6'h0E,
            6'h0F, 6'h20, 6'h23, 6'h27, 6'h2B, 6'h2C, 6'h3F, 6'h0D};
    for (int c = 0; c < 400; c++) begin
      w = {ops[$urandom_range(0, 17)], 26'($urandom)};
      drive_cycle(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 30) == 0));
      bad = 0;
      if (outValid !== (mq.size() != 0) || inReady !== (mq.size() < 2)) bad = 1;
      if (outValid2 !== (mq.size() != 0) || inReady2 !== (mq.size() < 2)) bad = 1;
      if (mq.size() != 0) begin
        if (outInstr !== mq[0] || outControl !== ref_ctrl(mq[0], 1'b1) ||
            outImm !== ref_imm(mq[0], 1'b1) || outHasImm !== ref_has(mq[0])) bad = 1;
        if (outInstr2 !== mq[0] || outControl2 !== ref_ctrl(mq[0], 1'b0) ||
            outImm2 !== ref_imm(mq[0], 1'b0) || outHasImm2 !== ref_has(mq[0])) bad = 1;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL random_%0d v=%b r=%b instr=%h ctl=%b imm=%h has=%b | nb ctl=%b imm=%h want occ=%0d head=%h",
                 c, outValid, inReady, outInstr, outControl, outImm, outHasImm, outControl2, outImm2,
                 mq.size(), (mq.size() != 0) ? mq[0] : 32'h0);
      end
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, 32'h3C08ABCD, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h2408FFFF, 1'b0, 1'b0);
    inValid = 1'b0;
    n_tests++; if (outValid !== 1'b1) begin n_fail++; $display("FAIL areset_pre got %b want 1", outValid); end
    #3;
    resetN = 1'b0;
    #1;
    n_tests++; if (outValid !== 1'b0 || inReady !== 1'b1) begin
      n_fail++; $display("FAIL areset_ctl valid=%b ready=%b want 0/1", outValid, inReady);
    end
    n_tests++; if (outInstr !== 32'h0 || outImm !== 32'h0 || outControl !== 3'b100 || outHasImm !== 1'b0) begin
      n_fail++; $display("FAIL areset_data instr=%h imm=%h ctl=%b has=%b want 0/0/100/0", outInstr, outImm, outControl, outHasImm);
    end
    #1;
    resetN = 1'b1;
    mq.delete();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_no_imm();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
